dut_bus_master: RTL
===================

Name: dut_bus_master

Overview:
- Upstream command engine that drives the dut register-style bus: write channel (write_address/write_data/write_en/write_rdy) and read channel (read_address/read_en/read_data/read_rdy).
- Accepts queued read/write commands from the test sequencer over a valid/ready port.
- Issues each command with the dut en/rdy handshake, one at a time, in order.
- Returns exactly one response per command: read data or write acknowledge, with a timeout error flag.

Parameters:
ADDR_W, 3, width of dut write/read addresses
CMD_DEPTH, 4, command FIFO entries; power of two, ≥2
TIMEOUT, 255, max cycles en may stay high without rdy before abort; 1..65535

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command FIFO not full
cmd_op  input  1  0=write, 1=read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  1  write data; ignored for reads
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_op  output  1  op of the completed command
rsp_data  output  1  read data; 0 for writes and errors
rsp_err  output  1  1 = command aborted by timeout
write_address  output  ADDR_W  to dut
write_data  output  1  to dut
write_en  output  1  to dut, registered
write_rdy  input  1  from dut
read_address  output  ADDR_W  to dut
read_en  output  1  to dut, registered
read_data  input  1  from dut, valid with read_rdy
read_rdy  input  1  from dut
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - Reset RST_N is asynchronous, active-low.
  - While RST_N=0, all outputs are 0 except cmd_ready=1: en, addresses, data, rsp_* and busy all 0. FIFO is emptied and FSM is forced to IDLE.
- Command FIFO:
  - cmd_ready = !full.
  - A push occurs at a rising edge with cmd_valid&&cmd_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If FIFO non-empty and rsp_valid=0: pop the head into the command register and go to ISSUE.
  - In the same edge, drive the selected channel's address/data and set its en=1 (write_en for op 0, read_en for op 1). The other en stays 0.
  - Clear the timeout counter.
- ISSUE:
  - en, address and data are held stable.
  - A transfer occurs at an edge where en=1 and the matching rdy=1.
  - Write transfer: en←0, rsp_data←0, rsp_err←0, go to RESP.
  - Read transfer: capture read_data into rsp_data, rsp_err←0, en←0, go to RESP.
  - No rdy: the counter increments. At the edge where the counter reaches TIMEOUT: en←0, rsp_data←0, rsp_err←1, go to RESP.
  - rdy on the same edge as the timeout takes priority: normal transfer.
- RESP:
  - rsp_valid=1 with rsp_op/rsp_data/rsp_err stable until an edge with rsp_ready=1.
  - That edge clears rsp_valid and returns to IDLE.
  - The next pop occurs at the following edge, so there is at most one command in flight.
- Latency:
  - Push at edge N into an empty FIFO with FSM in IDLE → en high after edge N+1.
  - With rdy=1 → transfer at edge N+2, rsp_valid high after N+2.
  - Minimum 2 cycles from acceptance to response; throughput is one command per 3 cycles.
- Ordering and invariants:
  - Responses are produced in command order, including timed-out commands.
  - write_en and read_en are never high simultaneously.
  - en is never high outside ISSUE.
- Reset mid-operation: an in-flight command and queued commands are dropped with no response. en deasserts asynchronously.

Test Plan:
- Write: push op=0 addr=4 data=1, write_rdy=1 → write_en high exactly 1 cycle with write_address=4, write_data=1; response rsp_op=0, rsp_data=0, rsp_err=0, rsp_valid 2 cycles after push edge.
- Read: push op=1 addr=3, read_rdy low 3 cycles then high with read_data=1 → read_en high 4 cycles, read_address=3 stable; response rsp_data=1, rsp_err=0.
- FIFO full/order: 5 back-to-back pushes with rsp_ready=0 → after 4th accepted... 1 popped, so 5th accepted and cmd_ready drops after it. Then rsp_ready=1 gives 5 responses in push order.
- Timeout: TIMEOUT=8, read with read_rdy=0 forever → read_en high exactly 8 cycles; response rsp_err=1, rsp_data=0; next queued write then completes normally.
- Backpressure: rsp_ready=0 for 10 cycles during RESP → rsp_valid and rsp fields held; no en asserted and no pop until handshake.
- Reset mid-ISSUE: RST_N low while write_en=1 → write_en, rsp_valid and busy 0 immediately (asynchronous); after release, no stale response and cmd_ready=1.

Source files
------------

// File: rtl/dut_bus_master.sv
// Command engine for the dut register-style bus: queues read/write commands,
// issues them one at a time with an en/rdy handshake, and returns one
// response per command (read data, write ack, or timeout error).
module dut_bus_master #(
  parameter int ADDR_W    = 3,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_wdata,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_op,
  output logic              rsp_data,
  output logic              rsp_err,
  // dut write channel
  output logic [ADDR_W-1:0] write_address,
  output logic              write_data,
  output logic              write_en,
  input  logic              write_rdy,
  // dut read channel
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic              read_data,
  input  logic              read_rdy,
  // status
  output logic              busy
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic              wdata;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  assign fifo_full  = (count_q == CNT_W'(CMD_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a full FIFO refuses pushes even on a pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer/count registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; emptiness is tracked by count_q, so stale entries are never read.
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata};
  end

  // ---------------------------------------------------------------------------
  // Issue / response FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic              write_data_q, write_data_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic              read_en_q, read_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_op_q, rsp_op_d;
  logic              rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              xfer_w;
  logic              xfer_r;

  assign xfer_w = write_en_q && write_rdy;
  assign xfer_r = read_en_q && read_rdy;

  // Next-state and registered-output logic; a rdy on the timeout edge wins.
  always_comb begin
    state_d         = state_q;
    tmo_cnt_d       = tmo_cnt_q;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    write_en_d      = write_en_q;
    read_address_d  = read_address_q;
    read_en_d       = read_en_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_op_d        = rsp_op_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    pop             = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !rsp_valid_q) begin
          pop       = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ISSUE;
          if (head.op) begin
            read_address_d = head.addr;
            read_en_d      = 1'b1;
          end else begin
            write_address_d = head.addr;
            write_data_d    = head.wdata;
            write_en_d      = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (xfer_w || xfer_r) begin
          write_en_d  = 1'b0;
          read_en_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_op_d    = read_en_q;
          rsp_data_d  = xfer_r ? read_data : 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          write_en_d  = 1'b0;
          read_en_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_op_d    = read_en_q;
          rsp_data_d  = 1'b0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM and bus/response registers; reset drops any in-flight command.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= IDLE;
      tmo_cnt_q       <= '0;
      write_address_q <= '0;
      write_data_q    <= 1'b0;
      write_en_q      <= 1'b0;
      read_address_q  <= '0;
      read_en_q       <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_op_q        <= 1'b0;
      rsp_data_q      <= 1'b0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_cnt_q       <= tmo_cnt_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      write_en_q      <= write_en_d;
      read_address_q  <= read_address_d;
      read_en_q       <= read_en_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_op_q        <= rsp_op_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign cmd_ready     = !fifo_full;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_op        = rsp_op_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign write_en      = write_en_q;
  assign read_address  = read_address_q;
  assign read_en       = read_en_q;
  assign busy          = !fifo_empty || (state_q != IDLE);

endmodule
